axis_rx_fifo: RTL
=================

AXIS_RX_FIFO -- requirements
Module: axis_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, tdata width in bits; it must be a multiple of 8.
REQ-002 SHALL have parameter USER_WIDTH, default 1, tuser width in bits.
REQ-003 SHALL have parameter DEPTH, default 8, FIFO entries; it must be a power of 2 and at least 2.
REQ-004 SHALL have port aclk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port areset, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have ports s_tdata (input, DATA_WIDTH), s_tkeep (input, DATA_WIDTH/8), s_tlast (input, 1) and s_tuser (input, USER_WIDTH): the AXI4-Stream slave payload.
REQ-007 SHALL have port s_tvalid, input, 1 bit, and port s_tready, output, 1 bit: the AXI4-Stream handshake.
REQ-008 SHALL have port flush, input, 1 bit: synchronous FIFO clear.
REQ-009 SHALL have port rd_en, input, 1 bit: pop request.
REQ-010 SHALL have ports rd_data (output, DATA_WIDTH), rd_keep (output, DATA_WIDTH/8), rd_last (output, 1) and rd_user (output, USER_WIDTH): the head entry.
REQ-011 SHALL have port rd_valid, output, 1 bit: the head entry is valid.
REQ-012 SHALL have port level, output, $clog2(DEPTH)+1 bits: number of stored entries.
REQ-013 SHALL have port underflow_err, output, 1 bit: sticky flag for a pop attempted while empty.
REQ-014 SHALL have port pkt_cnt, output, $clog2(DEPTH)+1 bits: number of complete packets stored (see Configuration).

Function
REQ-015 SHALL accept a beat on a rising edge where s_tvalid=1 and s_tready=1, writing {tdata, tkeep, tlast, tuser} at the write pointer.
REQ-016 SHALL drive s_tready = (level != DEPTH), decoded from registered state only, with no combinational path from s_tvalid or rd_en.
REQ-017 SHALL operate as first-word fall-through: rd_valid = (level != 0), and rd_* shows the head entry whenever rd_valid=1.
REQ-018 SHALL pop on a rising edge where rd_en=1 and rd_valid=1; rd_en while rd_valid=0 SHALL be ignored and SHALL set underflow_err.
REQ-019 SHALL have 1-cycle latency: a beat accepted at edge N drives rd_valid=1 with its data after edge N, when the FIFO was empty.
REQ-020 SHALL, on a simultaneous push and pop in the same edge, store the new beat, remove the head, and leave level unchanged.
REQ-021 SHALL NOT accept a push when full, even if a pop occurs on the same edge (s_tready is already 0).
REQ-022 SHALL NOT pop when empty, even if a push occurs on the same edge; the pushed beat becomes head after that edge.
REQ-023 SHALL keep read and write pointers $clog2(DEPTH) bits wide and wrap them modulo DEPTH.
REQ-024 SHALL keep level in the range 0..DEPTH at all times.
REQ-025 SHALL, when flush=1 at an edge, zero the pointers, level, pkt_cnt and underflow_err; flush SHALL take precedence over a simultaneous push or pop, and a beat presented in that cycle is accepted-and-discarded if s_tready=1.
REQ-026 SHALL NOT alter tvalid/tdata acceptance ordering: beats SHALL be output in arrival order, unmodified.

Reset
REQ-027 SHALL, while areset=1 at an edge, clear pointers, level=0, pkt_cnt=0 and underflow_err=0; consequently s_tready=1 and rd_valid=0 after that edge.
REQ-028 SHALL discard all stored beats on a reset asserted mid-packet; the next accepted beat starts fresh with no tlast bookkeeping carried over.
REQ-029 SHALL NOT require a reset of the storage array; rd_* content is don't-care while rd_valid=0.

Configuration
REQ-030 SHALL, when AXIS_RX_FIFO_PKT_CNT_EN is defined, increment pkt_cnt on each push with tlast=1, decrement it on each pop with rd_last=1, and leave it unchanged when both occur on the same edge.
REQ-031 SHALL, when AXIS_RX_FIFO_PKT_CNT_EN is undefined, keep the pkt_cnt port present, tie it to 0, and synthesize no counter logic.

Verification
REQ-032 SHALL cover: reset, then push 0xA5A5_0001 with tlast=1 -> rd_valid=1 next cycle, rd_data=0xA5A5_0001, rd_last=1, level=1, pkt_cnt=1 (macro on).
REQ-033 SHALL cover: DEPTH=8, push 8 beats with no pops -> s_tready=0 and level=8; s_tvalid held with rd_en=1 -> pop occurs, no push that edge, level=7, s_tready=1 next cycle.
REQ-034 SHALL cover: push 10 beats 0..9 while popping continuously -> output order 0..9, pointers wrap, and no loss or duplication.
REQ-035 SHALL cover: with 3 entries stored, flush=1 together with s_tvalid=1 and rd_en=1 -> level=0 and rd_valid=0 next cycle, and the beat is discarded.
REQ-036 SHALL cover: rd_en=1 while empty -> underflow_err=1 and it stays 1 until flush or areset; level stays 0.
REQ-037 SHALL cover: areset asserted mid-packet (2 of 4 beats stored) -> level=0 and pkt_cnt=0, and a subsequent 1-beat packet reads out correctly.

Source files
------------

// File: rtl/axis_rx_fifo.sv
// AXI4-Stream receive FIFO, first-word fall-through, with a sticky underflow flag.
// Optional stored-packet counter is enabled by defining AXIS_RX_FIFO_PKT_CNT_EN.
module axis_rx_fifo #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned USER_WIDTH = 1,
   parameter int unsigned DEPTH      = 8
) (
   input  logic                          aclk,
   input  logic                          areset,
   input  logic [DATA_WIDTH-1:0]         s_tdata,
   input  logic [DATA_WIDTH/8-1:0]       s_tkeep,
   input  logic                          s_tlast,
   input  logic [USER_WIDTH-1:0]         s_tuser,
   input  logic                          s_tvalid,
   output logic                          s_tready,
   input  logic                          flush,
   input  logic                          rd_en,
   output logic [DATA_WIDTH-1:0]         rd_data,
   output logic [DATA_WIDTH/8-1:0]       rd_keep,
   output logic                          rd_last,
   output logic [USER_WIDTH-1:0]         rd_user,
   output logic                          rd_valid,
   output logic [$clog2(DEPTH):0]        level,
   output logic                          underflow_err,
   output logic [$clog2(DEPTH):0]        pkt_cnt
);

   localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned AW         = $clog2(DEPTH);
   localparam int unsigned LW         = AW + 1;
   localparam int unsigned EW         = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH;

   logic [EW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          underflow_q, underflow_d;
   logic          push;
   logic          pop;
   logic [EW-1:0] head;

   // Handshake and status decode purely from registered occupancy.
   assign s_tready      = (level_q != LW'(DEPTH));
   assign rd_valid      = (level_q != '0);
   assign level         = level_q;
   assign underflow_err = underflow_q;

   // Flush wins: a beat offered during flush is handshaken but never stored.
   assign push = s_tvalid & s_tready & ~flush;
   assign pop  = rd_en & rd_valid & ~flush;

   assign head = mem_q[rd_ptr_q];
   assign {rd_data, rd_keep, rd_last, rd_user} = head;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      underflow_d = underflow_q;
      if (flush) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         level_d     = '0;
         underflow_d = 1'b0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
         endcase
         if (rd_en && !rd_valid) underflow_d = 1'b1;
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage needs no reset; content is only observed while rd_valid is high.
   always_ff @(posedge aclk) begin
      if (push) mem_q[wr_ptr_q] <= {s_tdata, s_tkeep, s_tlast, s_tuser};
   end

`ifdef AXIS_RX_FIFO_PKT_CNT_EN
   logic [LW-1:0] pkt_cnt_q, pkt_cnt_d;

   always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      if (flush) begin
         pkt_cnt_d = '0;
      end else begin
         case ({push & s_tlast, pop & rd_last})
            2'b10:   pkt_cnt_d = pkt_cnt_q + LW'(1);
            2'b01:   pkt_cnt_d = pkt_cnt_q - LW'(1);
            default: pkt_cnt_d = pkt_cnt_q;
         endcase
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) pkt_cnt_q <= '0;
      else        pkt_cnt_q <= pkt_cnt_d;
   end

   assign pkt_cnt = pkt_cnt_q;
`else
   assign pkt_cnt = '0;
`endif

endmodule
